shift_sequencer: RTL
====================

# shift_sequencer

Multi-cycle shift-unit controller for the MIPS execute stage. Sequences one shared combinational 32-bit logical right shifter to implement SLL, SRL and SRA:
- SLL uses bit reversal around the shifter.
- SRA uses a second mask pass.

It accepts one request at a time through a start/busy/done handshake and holds the result until the next accepted request.

## Interface
- DATA_W, 32, operand/result width; only 32 is supported.
- SHAMT_W, 5, shift-amount width; equals log2(DATA_W).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only when busy=0.
- op  in  2  operation: 2'b00 SLL, 2'b01 SRL, 2'b11 SRA, 2'b10 reserved (executes as SRL).
- dataIn  in  DATA_W  operand (rt value).
- shamt  in  SHAMT_W  shift amount, 0..31.
- busy  out  1  high while a request is in flight.
- done  out  1  one-cycle pulse; dataOut is valid from this cycle on.
- dataOut  out  DATA_W  result register; held until the next accepted start.

## Operation
States: IDLE, PASS_DATA, PASS_MASK, DONE.

- **IDLE / DONE:** busy=0.
  - start=1 latches op, shamt and operand into internal registers. The operand is bit-reversed when op=SLL.
  - Next state: PASS_DATA.
  - Otherwise: IDLE.
- **PASS_DATA:** busy=1. Shifter input = operand register, amount = latched shamt.
  - Result register <= shifter output, bit-reversed if op=SLL.
  - If op=SRA and operand[31]=1: go to PASS_MASK. Otherwise: go to DONE.
- **PASS_MASK:** busy=1. Shifter input = all-ones, same amount.
  - Result register <= result | ~shifterOut, which fills the top shamt bits with 1.
  - Next state: DONE.
- **DONE:** done=1 for this cycle only. Behaves as IDLE for start acceptance, so back-to-back requests are allowed.

Other rules:
- The mask pass runs for every negative SRA, including shamt=0. For shamt=0 the result is unchanged.
- start while busy=1 is ignored, not queued. Inputs are don't-care while busy.
- Shifter reset/enable input is tied inactive; sequencing is owned entirely by this block.
- Arithmetic: no carries; all values are DATA_W bits; shamt is unsigned.

## Timing
- Request accepted at edge T.
- done and new dataOut appear in cycle T+2 for SLL, SRL and non-negative SRA.
- done and new dataOut appear in cycle T+3 for negative SRA.
- dataOut changes only on the edge entering DONE. It is stable in all other cycles, including while the next request is busy.
- Reset values: state IDLE, busy=0, done=0, dataOut=0, all internal registers 0.
- Reset asserted in any state, including mid PASS_MASK, takes effect at that edge:
  - Outputs return to reset values.
  - No done is produced for the aborted request.
- start coincident with reset is ignored.
- Simultaneous start in DONE: done still pulses that cycle. The new request enters PASS_DATA on the next edge, and busy=1 from that cycle.

## Structure
- Shared package (shift_pkg): DATA_W/SHAMT_W constants, op encodings (OP_SLL, OP_SRL, OP_SRA), state enum, bit-reverse function.
- One sub-module: srl_core, a combinational DATA_W-bit logical right shifter (dataIn, shamt -> dataOut), five mux stages with strides 1/2/4/8/16 and zero fill.
- Instantiate exactly one srl_core. The FSM, operand/result registers and reversal logic live in shift_sequencer.

## Test plan
- SRL 0x80000000 by 4 -> done at T+2, dataOut=0x08000000. SRL 0x12345678 by 16 -> 0x00001234. SRL by 17 -> 0x0000091A, which checks the stride-16 stage.
- SLL 0x00000001 by 31 -> 0x80000000 at T+2. SLL 0x12345678 by 0 -> 0x12345678.
- SRA 0xF0000000 by 4 -> 0xFF000000 at T+3. SRA 0x70000000 by 4 -> 0x07000000 at T+2. SRA 0x80000000 by 31 -> 0xFFFFFFFF.
- start pulsed in PASS_DATA -> ignored, exactly one done. start held in the DONE cycle -> second request accepted, its done 2 cycles later, first result visible in between.
- reset asserted during PASS_MASK -> next cycle busy=0, done=0, dataOut=0, no done pulse afterwards.
- op=2'b10 on 0xFFFFFFFF by 8 -> 0x00FFFFFF (executes as SRL).

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared constants, op encodings, FSM states and bit-reverse helper for the shift unit
package shift_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PASS_DATA = 2'b01,
        PASS_MASK = 2'b10,
        DONE      = 2'b11
    } shift_state_t;

    // Mirror a word so a right shifter can perform a left shift.
    function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/srl_core.sv
// rtl/srl_core.sv - combinational 32-bit logical right shifter, five zero-filling mux stages
module srl_core
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0]  dataIn,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  dataOut
);

    logic [DATA_W-1:0] stage1;
    logic [DATA_W-1:0] stage2;
    logic [DATA_W-1:0] stage4;
    logic [DATA_W-1:0] stage8;

    // Each stage conditionally shifts by its stride, filling vacated bits with zero.
    assign stage1  = shamt[0] ? {1'b0,  dataIn[DATA_W-1:1]}  : dataIn;
    assign stage2  = shamt[1] ? {2'b0,  stage1[DATA_W-1:2]}  : stage1;
    assign stage4  = shamt[2] ? {4'b0,  stage2[DATA_W-1:4]}  : stage2;
    assign stage8  = shamt[3] ? {8'b0,  stage4[DATA_W-1:8]}  : stage4;
    assign dataOut = shamt[4] ? {16'b0, stage8[DATA_W-1:16]} : stage8;

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle SLL/SRL/SRA controller around one shared logical right shifter
module shift_sequencer
    import shift_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [DATA_W-1:0]  dataIn,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  dataOut
);

    shift_state_t       state_q;
    shift_state_t       state_d;
    logic [1:0]         op_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic [DATA_W-1:0]  operand_q;
    logic [DATA_W-1:0]  partial_q;
    logic [DATA_W-1:0]  shift_in;
    logic [DATA_W-1:0]  shift_out;
    logic [DATA_W-1:0]  data_pass;
    logic               accept;

    srl_core u_srl_core (
        .dataIn  (shift_in),
        .shamt   (shamt_q),
        .dataOut (shift_out)
    );

    // A new request is only taken when nothing is in flight.
    assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
    assign data_pass = (op_q == OP_SLL) ? bit_reverse(shift_out) : shift_out;

    // Next-state, handshake outputs and shifter input selection.
    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        shift_in = operand_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = PASS_DATA;
            end
            PASS_DATA: begin
                busy = 1'b1;
                if ((op_q == OP_SRA) && operand_q[DATA_W-1]) state_d = PASS_MASK;
                else                                          state_d = DONE;
            end
            PASS_MASK: begin
                busy     = 1'b1;
                shift_in = '1;
                state_d  = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? PASS_DATA : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request latches and result; dataOut is only written on the edge entering DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            shamt_q   <= '0;
            operand_q <= '0;
            partial_q <= '0;
            dataOut   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q      <= op;
                shamt_q   <= shamt;
                operand_q <= (op == OP_SLL) ? bit_reverse(dataIn) : dataIn;
            end
            if (state_q == PASS_DATA) begin
                if (state_d == PASS_MASK) partial_q <= data_pass;
                else                      dataOut   <= data_pass;
            end
            if (state_q == PASS_MASK) begin
                dataOut <= partial_q | ~shift_out;
            end
        end
    end

endmodule
